valu_sequencer: RTL

Sequencer that drives the vector ALU (`alu`) across the elements of a vector operation. It accepts one command per handshake: op plus vector length. It streams operand pairs element-by-element out of a synchronous-read vector register file port and writes each registered ALU result back to the destination port. It also reports per-command summary flags on a one-cycle done pulse. It sits between the vector issue stage and the register file / ALU lane.

---
 rtl/valu_pkg.sv | 20 ++
 rtl/alu.sv | 64 ++++++
 rtl/valu_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/valu_pkg.sv
// Shared types for the vector ALU sequencer: opcodes, FSM states and pipeline depth.
package valu_pkg;

  typedef enum logic [1:0] {
    e_add = 2'd0,
    e_sub = 2'd1,
    e_mul = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    s_idle,
    s_run,
    s_drain,
    s_done
  } state_e;

  // Cycles from a register file read to the matching write-back.
  localparam int pipe_depth_lp = 2;

endpackage

// File: rtl/alu.sv
// Single-lane two's complement ALU with a registered result and per-result flags.
module alu
  import valu_pkg::*;
#(
  parameter int vdw_p      = 32,
  parameter int op_width_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [op_width_p-1:0]   op_i,
  input  logic signed [vdw_p-1:0] a_i,
  input  logic signed [vdw_p-1:0] b_i,
  output logic signed [vdw_p-1:0] result_o,
  output logic                    overflow_o,
  output logic                    negative_o,
  output logic                    zero_o
);

  // Returns {overflow, result}; mul keeps the low half and flags a product that does not fit.
  function automatic logic [vdw_p:0] calc(input logic [op_width_p-1:0] op,
                                          input logic signed [vdw_p-1:0] a,
                                          input logic signed [vdw_p-1:0] b);
    logic signed [vdw_p-1:0]   r;
    logic signed [2*vdw_p-1:0] p;
    logic                      ov;
    p = '0;
    case (op_e'(op))
      e_sub: begin
        r  = a - b;
        ov = (a[vdw_p-1] != b[vdw_p-1]) && (r[vdw_p-1] != a[vdw_p-1]);
      end
      e_mul: begin
        p  = (2*vdw_p)'(a) * (2*vdw_p)'(b);
        r  = p[vdw_p-1:0];
        ov = (p != (2*vdw_p)'(r));
      end
      default: begin
        r  = a + b;
        ov = (a[vdw_p-1] == b[vdw_p-1]) && (r[vdw_p-1] != a[vdw_p-1]);
      end
    endcase
    return {ov, r};
  endfunction

  logic [vdw_p:0] calc_p0;
  assign calc_p0 = calc(op_i, a_i, b_i);

  // p0 -> p1: operands in, registered result and flags out
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_o   <= '0;
      overflow_o <= 1'b0;
      negative_o <= 1'b0;
      zero_o     <= 1'b0;
    end else if (v_i) begin
      result_o   <= calc_p0[vdw_p-1:0];
      overflow_o <= calc_p0[vdw_p];
      negative_o <= calc_p0[vdw_p-1];
      zero_o     <= (calc_p0[vdw_p-1:0] == '0);
    end
  end

endmodule

// File: rtl/valu_sequencer.sv
// Streams one vector command element-by-element through the ALU lane and writes the
// results back, reporting accumulated overflow/negative/zero flags on a done pulse.
module valu_sequencer
  import valu_pkg::*;
#(
  parameter int vdw_p      = 32,
  parameter int op_width_p = 2,
  parameter int els_p      = 16,
  localparam int lg_els_lp    = $clog2(els_p),
  localparam int len_width_lp = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [op_width_p-1:0]   op_i,
  input  logic [len_width_lp-1:0] len_i,
  output logic                    rd_v_o,
  output logic [lg_els_lp-1:0]    rd_addr_o,
  input  logic [vdw_p-1:0]        rd_a_data_i,
  input  logic [vdw_p-1:0]        rd_b_data_i,
  output logic                    wr_v_o,
  output logic [lg_els_lp-1:0]    wr_addr_o,
  output logic [vdw_p-1:0]        wr_data_o,
  output logic                    done_o,
  output logic                    any_overflow_o,
  output logic                    any_negative_o,
  output logic                    all_zero_o
);

  localparam int drain_w_lp = (pipe_depth_lp > 1) ? $clog2(pipe_depth_lp) : 1;

  state_e                    state_r;
  logic [op_width_p-1:0]     op_r;
  logic [len_width_lp-1:0]   len_r;
  logic [len_width_lp-1:0]   len_clamped;
  logic [drain_w_lp-1:0]     drain_cnt_r;
  logic                      last_rd;

  logic                      vld_p0, vld_p1;
  logic [lg_els_lp-1:0]      idx_p0, idx_p1;
  logic signed [vdw_p-1:0]   res_p1;
  logic                      ov_p1, neg_p1, zero_p1;

  assign len_clamped = (len_i > len_width_lp'(els_p)) ? len_width_lp'(els_p) : len_i;
  assign last_rd     = (len_width_lp'(rd_addr_o) + len_width_lp'(1)) == len_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= s_idle;
      ready_o        <= 1'b1;
      rd_v_o         <= 1'b0;
      rd_addr_o      <= '0;
      done_o         <= 1'b0;
      op_r           <= '0;
      len_r          <= '0;
      drain_cnt_r    <= '0;
      any_overflow_o <= 1'b0;
      any_negative_o <= 1'b0;
      all_zero_o     <= 1'b1;
    end else begin
      done_o <= 1'b0;
      if (vld_p1) begin
        any_overflow_o <= any_overflow_o | ov_p1;
        any_negative_o <= any_negative_o | neg_p1;
        all_zero_o     <= all_zero_o & zero_p1;
      end
      case (state_r)
        s_idle: begin
          if (v_i) begin
            op_r           <= op_i;
            len_r          <= len_clamped;
            rd_addr_o      <= '0;
            ready_o        <= 1'b0;
            any_overflow_o <= 1'b0;
            any_negative_o <= 1'b0;
            all_zero_o     <= 1'b1;
            if (len_clamped == '0) begin
              state_r <= s_done;
              done_o  <= 1'b1;
            end else begin
              state_r <= s_run;
              rd_v_o  <= 1'b1;
            end
          end
        end
        s_run: begin
          if (last_rd) begin
            rd_v_o      <= 1'b0;
            rd_addr_o   <= '0;
            drain_cnt_r <= '0;
            state_r     <= s_drain;
          end else begin
            rd_addr_o <= rd_addr_o + lg_els_lp'(1);
          end
        end
        s_drain: begin
          if (drain_cnt_r == drain_w_lp'(pipe_depth_lp - 1)) begin
            state_r <= s_done;
            done_o  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + drain_w_lp'(1);
          end
        end
        s_done: begin
          state_r <= s_idle;
          ready_o <= 1'b1;
        end
        default: state_r <= s_idle;
      endcase
    end
  end

  // read issue -> p0 (operands arrive) -> p1 (result written back)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      idx_p0 <= '0;
      idx_p1 <= '0;
    end else begin
      vld_p0 <= rd_v_o;
      idx_p0 <= rd_addr_o;
      vld_p1 <= vld_p0;
      idx_p1 <= idx_p0;
    end
  end

  alu #(
    .vdw_p      (vdw_p),
    .op_width_p (op_width_p)
  ) u_alu (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (vld_p0),
    .op_i       (op_r),
    .a_i        (rd_a_data_i),
    .b_i        (rd_b_data_i),
    .result_o   (res_p1),
    .overflow_o (ov_p1),
    .negative_o (neg_p1),
    .zero_o     (zero_p1)
  );

  assign wr_v_o    = vld_p1;
  assign wr_addr_o = idx_p1;
  assign wr_data_o = res_p1;

endmodule
